// File: rtl/prog_load_pkg.sv
// Shared definitions for the program-load controller: FSM state encoding
// and default timing parameters.
package prog_load_pkg;

   // Controller states, 3-bit encoding.
   typedef enum logic [2:0] {
      STATE_IDLE  = 3'd0,
      STATE_LOAD  = 3'd1,
      STATE_DRAIN = 3'd2,
      STATE_HOLD  = 3'd3,
      STATE_RUN   = 3'd4,
      STATE_ERR   = 3'd5
   } state_t;

   // Idle cycles tolerated between bytes while loading (8-bit counter).
   localparam int DEF_TIMEOUT  = 255;
   // Cycles the core stays in reset after the final RAM write.
   localparam int DEF_RST_HOLD = 4;

endpackage

// File: rtl/prog_load_timer.sv
// Generic loadable down-counter. The count is loaded while load is high,
// decrements while en is high, and saturates at zero; zero flags expiry.
module prog_load_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_value,
   output logic         zero
);

   logic [W-1:0] count_reg;

   // Load has priority over counting; the counter stops at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (en && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/prog_load_ctrl.sv
// Boot/program-load controller. Accepts a byte stream over valid/ready,
// writes each byte into instruction RAM one cycle after acceptance, holds
// the core in reset while loading and releases it after a short hold.
// Optional build macro: PROG_LOAD_CHECKSUM_EN -- the byte flagged byte_last
// is a checksum (not written); the 8-bit sum of written bytes plus the
// checksum must be zero, otherwise the load ends in the error state.
module prog_load_ctrl
   import prog_load_pkg::*;
#(
   parameter int ADDR_W   = 7,
   parameter int TIMEOUT  = DEF_TIMEOUT,
   parameter int RST_HOLD = DEF_RST_HOLD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              core_rst_n,
   output logic              busy,
   output logic              load_done,
   output logic              error
);

   state_t            state_reg;
   state_t            state_next;
   logic [ADDR_W-1:0] count_reg;
   logic              mem_we_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [7:0]        mem_data_reg;
   logic              core_rst_n_reg;
   logic              busy_reg;
   logic              load_done_reg;
   logic              error_reg;

   logic accept;
   logic write_en;
   logic full;
   logic last_ok;
   logic tmo_zero;
   logic hold_zero;

   assign byte_ready = (state_reg == STATE_LOAD);
   assign accept     = byte_valid && byte_ready;
   assign full       = (count_reg == {ADDR_W{1'b1}});

`ifdef PROG_LOAD_CHECKSUM_EN
   logic [7:0] sum_reg;
   logic [7:0] sum_next;

   // The checksum byte closes the stream and is never written to RAM.
   assign write_en = accept && !byte_last;
   assign sum_next = sum_reg + byte_data;
   assign last_ok  = (sum_next == 8'h00);

   // Running modular sum of the bytes written during this load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_reg <= 8'h00;
      end else if (state_reg != STATE_LOAD) begin
         sum_reg <= 8'h00;
      end else if (write_en) begin
         sum_reg <= sum_next;
      end
   end
`else
   assign write_en = accept;
   assign last_ok  = 1'b1;
`endif

   // Inter-byte timeout: reloaded on every accept and outside LOAD, so it
   // expires after TIMEOUT consecutive LOAD cycles without an accepted byte.
   prog_load_timer #(.W(8)) u_timeout (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (accept || (state_reg != STATE_LOAD)),
      .en         (state_reg == STATE_LOAD),
      .load_value (8'(TIMEOUT - 1)),
      .zero       (tmo_zero)
   );

   // Reset-hold count: armed outside HOLD, runs for RST_HOLD HOLD cycles.
   prog_load_timer #(.W(8)) u_hold (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (state_reg != STATE_HOLD),
      .en         (state_reg == STATE_HOLD),
      .load_value (8'(RST_HOLD - 1)),
      .zero       (hold_zero)
   );

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         STATE_IDLE, STATE_RUN, STATE_ERR: begin
            if (load_start) state_next = STATE_LOAD;
         end
         STATE_LOAD: begin
            if (accept) begin
               if (byte_last)  state_next = last_ok ? STATE_DRAIN : STATE_ERR;
               else if (full)  state_next = STATE_DRAIN;
            end else if (tmo_zero) begin
               state_next = STATE_ERR;
            end
         end
         STATE_DRAIN: state_next = STATE_HOLD;
         STATE_HOLD: begin
            if (hold_zero) state_next = STATE_RUN;
         end
         default: state_next = STATE_IDLE;
      endcase
   end

   // State register plus Moore outputs decoded from the upcoming state so
   // they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= STATE_IDLE;
         core_rst_n_reg <= 1'b0;
         busy_reg       <= 1'b0;
         load_done_reg  <= 1'b0;
         error_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         core_rst_n_reg <= (state_next == STATE_RUN);
         busy_reg       <= state_next inside {STATE_LOAD, STATE_DRAIN, STATE_HOLD};
         load_done_reg  <= (state_next == STATE_RUN) && (state_reg != STATE_RUN);
         error_reg      <= (state_next == STATE_ERR);
      end
   end

   // Write path: one-cycle write latency; address and data hold when idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_we_reg   <= 1'b0;
         mem_addr_reg <= '0;
         mem_data_reg <= 8'h00;
         count_reg    <= '0;
      end else begin
         mem_we_reg <= write_en;
         if (write_en) begin
            mem_addr_reg <= count_reg;
            mem_data_reg <= byte_data;
         end
         if (state_reg != STATE_LOAD) begin
            count_reg <= '0;
         end else if (write_en) begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   assign mem_we     = mem_we_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_data   = mem_data_reg;
   assign core_rst_n = core_rst_n_reg;
   assign busy       = busy_reg;
   assign load_done  = load_done_reg;
   assign error      = error_reg;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl. Inputs change and outputs are sampled
// on the falling edge; the design acts on the rising edge.
// Status vector layout: {byte_ready, mem_we, core_rst_n, busy, load_done, error}
// Write vector layout:  {mem_we, mem_addr, mem_data}
module tb_prog_load_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_start;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_last;
   logic       byte_ready;
   logic       mem_we;
   logic [6:0] mem_addr;
   logic [7:0] mem_data;
   logic       core_rst_n;
   logic       busy;
   logic       load_done;
   logic       error;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   prog_load_ctrl #(.ADDR_W(7), .TIMEOUT(255), .RST_HOLD(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_last  (byte_last),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .core_rst_n (core_rst_n),
      .busy       (busy),
      .load_done  (load_done),
      .error      (error)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] sts();
      return {byte_ready, mem_we, core_rst_n, busy, load_done, error};
   endfunction

   function automatic logic [15:0] wr();
      return {mem_we, mem_addr, mem_data};
   endfunction

   logic [7:0] prog [8];
   logic [7:0] d;

   initial begin
      prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      rst_n = 1'b0; load_start = 1'b0; byte_valid = 1'b0;
      byte_data = 8'h00; byte_last = 1'b0;

      // Reset values
      repeat (2) tick();
      chk("rst_sts", 32'(sts()), 32'h0);
      chk("rst_wr", 32'(wr()), 32'h0);
      rst_n = 1'b1;
      tick();
      chk("idle_sts", 32'(sts()), 32'h0);

`ifdef PROG_LOAD_CHECKSUM_EN
      // Good checksum: 0x01 + 0x02 + 0xFD = 0x00 -> two writes, then RUN
      load_start = 1'b1; tick(); load_start = 1'b0;
      chk("ck_load", 32'(sts()), 32'(6'b100100));
      byte_valid = 1'b1; byte_data = 8'h01; tick();
      chk("ck_wr0", 32'(wr()), 32'({1'b1, 7'd0, 8'h01}));
      byte_data = 8'h02; tick();
      chk("ck_wr1", 32'(wr()), 32'({1'b1, 7'd1, 8'h02}));
      byte_data = 8'hFD; byte_last = 1'b1; tick();
      byte_valid = 1'b0; byte_last = 1'b0;
      chk("ck_drain", 32'(sts()), 32'(6'b000100));
      chk("ck_nowr", 32'(wr()), 32'({1'b0, 7'd1, 8'h02}));
      repeat (5) tick();
      chk("ck_run", 32'(sts()), 32'(6'b001010));
      // Bad checksum: 0x01 + 0x02 + 0xFE = 0x01 -> ERR
      load_start = 1'b1; tick(); load_start = 1'b0;
      byte_valid = 1'b1; byte_data = 8'h01; tick();
      byte_data = 8'h02; tick();
      byte_data = 8'hFE; byte_last = 1'b1; tick();
      byte_valid = 1'b0; byte_last = 1'b0;
      chk("ck_err", 32'(sts()), 32'(6'b000001));
      tick();
      chk("ck_err_stay", 32'(sts()), 32'(6'b000001));
`else
      // Eight back-to-back bytes, last flagged
      load_start = 1'b1; tick(); load_start = 1'b0;
      chk("t1_load", 32'(sts()), 32'(6'b100100));
      for (int i = 0; i < 8; i++) begin
         byte_valid = 1'b1; byte_data = prog[i]; byte_last = (i == 7);
         tick();
         chk($sformatf("t1_wr%0d", i), 32'(wr()), 32'({1'b1, 7'(i), prog[i]}));
         chk($sformatf("t1_sts%0d", i), 32'(sts()),
             32'((i == 7) ? 6'b010100 : 6'b110100));
      end
      byte_valid = 1'b0; byte_last = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("t1_hold%0d", k), 32'(sts()), 32'(6'b000100));
      end
      tick();
      chk("t1_run", 32'(sts()), 32'(6'b001010));
      byte_valid = 1'b1; byte_data = 8'hC3;
      tick();
      chk("t1_run_ignore", 32'(sts()), 32'(6'b001000));
      byte_valid = 1'b0;

      // Restart from RUN, then fill all 128 bytes without byte_last
      load_start = 1'b1; tick(); load_start = 1'b0;
      chk("t2_restart", 32'(sts()), 32'(6'b100100));
      for (int i = 0; i < 128; i++) begin
         d = 8'(i) ^ 8'h5A;
         byte_valid = 1'b1; byte_data = d;
         tick();
         chk($sformatf("t2_wr%0d", i), 32'(wr()), 32'({1'b1, 7'(i), d}));
         chk($sformatf("t2_sts%0d", i), 32'(sts()),
             32'((i == 127) ? 6'b010100 : 6'b110100));
      end
      byte_data = 8'hEE;   // 129th byte offered, must never be taken
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("t2_hold%0d", k), 32'(sts()), 32'(6'b000100));
         chk($sformatf("t2_nowr%0d", k), 32'(wr()), 32'({1'b0, 7'd127, 8'h25}));
      end
      tick();
      chk("t2_run", 32'(sts()), 32'(6'b001010));
      byte_valid = 1'b0;

      // One byte then 255 idle cycles -> ERR
      load_start = 1'b1; tick(); load_start = 1'b0;
      byte_valid = 1'b1; byte_data = 8'hAB;
      tick();
      chk("t3_wr", 32'(wr()), 32'({1'b1, 7'd0, 8'hAB}));
      byte_valid = 1'b0;
      repeat (254) tick();
      chk("t3_pre_tmo", 32'(sts()), 32'(6'b100100));
      tick();
      chk("t3_err", 32'(sts()), 32'(6'b000001));
      load_start = 1'b1; tick(); load_start = 1'b0;
      chk("t3_clear", 32'(sts()), 32'(6'b100100));
      byte_valid = 1'b1; byte_data = 8'h77; byte_last = 1'b1;
      tick();
      chk("t3_wr0", 32'(wr()), 32'({1'b1, 7'd0, 8'h77}));
      chk("t3_drain", 32'(sts()), 32'(6'b010100));
      byte_valid = 1'b0; byte_last = 1'b0;
      repeat (5) tick();
      chk("t3_run", 32'(sts()), 32'(6'b001010));

      // Reset mid-load after three bytes; load_start during LOAD is ignored
      load_start = 1'b1; tick(); load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         d = 8'h11 * 8'(i + 1);
         byte_valid = 1'b1; byte_data = d; load_start = (i == 1);
         tick();
         load_start = 1'b0;
         chk($sformatf("t5_wr%0d", i), 32'(wr()), 32'({1'b1, 7'(i), d}));
      end
      rst_n = 1'b0; byte_data = 8'h44;
      tick();
      chk("t5_rst_sts", 32'(sts()), 32'h0);
      chk("t5_rst_wr", 32'(wr()), 32'h0);
      rst_n = 1'b1; byte_valid = 1'b0;
      tick();
      chk("t5_idle", 32'(sts()), 32'h0);
      load_start = 1'b1; tick(); load_start = 1'b0;
      byte_valid = 1'b1; byte_data = 8'h55; byte_last = 1'b1;
      tick();
      chk("t5_wr_after", 32'(wr()), 32'({1'b1, 7'd0, 8'h55}));
      byte_valid = 1'b0; byte_last = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
